// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Round-robin sharing of one uart_tx serializer among NUM_REQ byte
//           producers. Optional macro UART_TX_ARB_TAG_EN sends a tag frame
//           {4'hA, grant_id} ahead of every payload byte.
// Revision: 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [DATA_WIDTH-1:0]         o_tx_data,
  output logic                          o_tx_start,
  input  logic                          i_tx_busy,
  input  logic                          i_tx_done,
  output logic [3:0]                    o_grant_id,
  output logic                          o_arb_busy,
  output logic [15:0]                   o_frame_cnt
);

  localparam logic [4:0] c_NUM_REQ = 5'(NUM_REQ);
  localparam int         c_EXT_W   = 16 * DATA_WIDTH;

`ifdef UART_TX_ARB_TAG_EN
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LAUNCH     = 3'd1,
    S_WAIT       = 3'd2,
    S_TAG_LAUNCH = 3'd3,
    S_TAG_WAIT   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2
  } state_t;
`endif

  state_t                r_state;
  logic [3:0]            r_rr_ptr;
  logic                  r_tx_start;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [3:0]            r_grant_id;
  logic [15:0]           r_frame_cnt;
`ifdef UART_TX_ARB_TAG_EN
  logic [DATA_WIDTH-1:0] r_payload;
  logic [DATA_WIDTH-1:0] w_tag;
`endif

  logic [15:0]           w_valid16;
  logic [c_EXT_W-1:0]    w_data_ext;
  logic [3:0]            w_win;
  logic [DATA_WIDTH-1:0] w_win_data;
  logic                  w_xfer;

  // Sums never exceed 2*NUM_REQ-2, so one conditional subtract is a full modulo.
  function automatic logic [3:0] f_wrap(input logic [4:0] a);
    return (a >= c_NUM_REQ) ? 4'(a - c_NUM_REQ) : a[3:0];
  endfunction

  assign w_valid16  = 16'(i_req_valid);
  assign w_data_ext = c_EXT_W'(i_req_data);

  // Descending scan so the candidate closest to r_rr_ptr is the last one written.
  always_comb begin
    w_win = r_rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_valid16[f_wrap({1'b0, r_rr_ptr} + 5'(k))]) begin
        w_win = f_wrap({1'b0, r_rr_ptr} + 5'(k));
      end
    end
  end

  assign w_win_data = w_data_ext[w_win*DATA_WIDTH +: DATA_WIDTH];
  assign w_xfer     = (r_state == S_IDLE) && (|i_req_valid) && !rst;
`ifdef UART_TX_ARB_TAG_EN
  assign w_tag      = DATA_WIDTH'({4'hA, w_win});
`endif

  always_comb begin
    o_req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      o_req_ready[i] = w_xfer && (w_win == 4'(i));
    end
  end

  // When the serializer is already idle at the handshake, the launch step is
  // folded into the handshake so tx_start appears on the very next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
      r_grant_id  <= '0;
      r_frame_cnt <= '0;
`ifdef UART_TX_ARB_TAG_EN
      r_payload   <= '0;
`endif
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_grant_id <= w_win;
            r_rr_ptr   <= f_wrap({1'b0, w_win} + 5'd1);
`ifdef UART_TX_ARB_TAG_EN
            r_payload  <= w_win_data;
            r_tx_data  <= w_tag;
            if (!i_tx_busy) begin
              r_tx_start <= 1'b1;
              r_state    <= S_TAG_WAIT;
            end else begin
              r_state    <= S_TAG_LAUNCH;
            end
`else
            r_tx_data  <= w_win_data;
            if (!i_tx_busy) begin
              r_tx_start <= 1'b1;
              r_state    <= S_WAIT;
            end else begin
              r_state    <= S_LAUNCH;
            end
`endif
          end
        end
        S_LAUNCH: begin
          if (!i_tx_busy) begin
            r_tx_start <= 1'b1;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_tx_done) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_state     <= S_IDLE;
          end
        end
`ifdef UART_TX_ARB_TAG_EN
        S_TAG_LAUNCH: begin
          if (!i_tx_busy) begin
            r_tx_start <= 1'b1;
            r_state    <= S_TAG_WAIT;
          end
        end
        S_TAG_WAIT: begin
          if (i_tx_done) begin
            r_tx_data <= r_payload;
            r_state   <= S_LAUNCH;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx_data   = r_tx_data;
  assign o_tx_start  = r_tx_start;
  assign o_grant_id  = r_grant_id;
  assign o_arb_busy  = (r_state != S_IDLE);
  assign o_frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// Bench for uart_tx_arbiter: directed scenarios plus random traffic checked
// against a queue-based round-robin model and a behavioural uart_tx.
module tb_uart_tx_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int FLEN = 6;
`ifdef UART_TX_ARB_TAG_EN
  localparam int FPH = 2;
`else
  localparam int FPH = 1;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NR-1:0]  req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]  req_ready;
  logic [DW-1:0]  tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic           tx_done;
  logic [3:0]     grant_id;
  logic           arb_busy;
  logic [15:0]    frame_cnt;

  logic           m_busy = 1'b0;
  logic           m_done = 1'b0;
  int             m_cnt = 0;
  logic           f_busy = 1'b0;
  logic           spur_done = 1'b0;
  logic [7:0]     line_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  assign tx_busy = m_busy | f_busy;
  assign tx_done = m_done | spur_done;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .o_tx_data   (tx_data),
    .o_tx_start  (tx_start),
    .i_tx_busy   (tx_busy),
    .i_tx_done   (tx_done),
    .o_grant_id  (grant_id),
    .o_arb_busy  (arb_busy),
    .o_frame_cnt (frame_cnt)
  );

  // Behavioural serializer: captures the byte on tx_start, busy for FLEN cycles.
  always @(negedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (tx_start) begin
        line_q.push_back(tx_data);
        m_busy <= 1'b1;
        m_cnt  <= FLEN;
      end else if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
      end
    end
  end

  function automatic int mwin(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      if (v[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [7:0] tagb(input int g);
    return {4'hA, g[3:0]};
  endfunction

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = '0; f_busy = 1'b0; spur_done = 1'b0;
    tick; tick;
    rst = 1'b0;
    line_q.delete();
  endtask

  task automatic wait_quiet(input int budget, output bit to);
    to = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (!arb_busy && !tx_busy && !tx_done) begin
        to = 1'b0;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = '0;
    tick;
    n_tests++;
    if ({req_ready, arb_busy, tx_start, tx_data, grant_id, frame_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: ready=%b busy=%b start=%b data=%h gid=%0d cnt=%0d want all zero",
               req_ready, arb_busy, tx_start, tx_data, grant_id, frame_cnt);
    end
    rst = 1'b0;
    tick;
    n_tests++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready_idle: got %b want 0000", req_ready);
    end
  endtask

  task automatic test_single;
    bit to;
    logic [7:0] exp_first;
    do_reset;
    req_data[0 +: DW] = 8'h55;
    req_valid = 4'b0001;
    #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    tick;
    req_valid = '0;
    exp_first = (FPH == 2) ? tagb(0) : 8'h55;
    n_tests++;
    if (tx_start !== 1'b1 || tx_data !== exp_first) begin
      n_fail++; $display("FAIL single_start: start=%b data=%h want 1 %h", tx_start, tx_data, exp_first);
    end
    wait_quiet(200, to);
    n_tests++;
    if (to || frame_cnt !== 16'd1 || line_q.size() != FPH || line_q[FPH-1] !== 8'h55) begin
      n_fail++; $display("FAIL single_done: timeout=%0d cnt=%0d frames=%0d want cnt 1 frames %0d", to, frame_cnt, line_q.size(), FPH);
    end
  endtask

  task automatic test_rotation;
    int exp_g[5];
    logic [7:0] exp_q[$];
    int got;
    bit to, bad;
    exp_g = '{0, 1, 2, 3, 0};
    do_reset;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 8'(8'h10 + i);
    req_valid = 4'hF;
    got = 0;
    #1;
    for (int c = 0; c < 600 && got < 5; c++) begin
      if (req_ready !== 4'b0000) begin
        n_tests++;
        if (req_ready !== 4'(1 << exp_g[got])) begin
          n_fail++; $display("FAIL rot_ready[%0d]: got %b want %b", got, req_ready, 4'(1 << exp_g[got]));
        end
        tick;
        n_tests++;
        if (grant_id !== 4'(exp_g[got])) begin
          n_fail++; $display("FAIL rot_grant[%0d]: got %0d want %0d", got, grant_id, exp_g[got]);
        end
        got++;
      end else begin
        tick;
      end
    end
    req_valid = '0;
    wait_quiet(200, to);
    for (int k = 0; k < 5; k++) begin
      if (FPH == 2) exp_q.push_back(tagb(exp_g[k]));
      exp_q.push_back(8'(8'h10 + exp_g[k]));
    end
    bad = (line_q.size() != exp_q.size());
    for (int k = 0; k < exp_q.size() && !bad; k++) if (line_q[k] !== exp_q[k]) bad = 1'b1;
    n_tests++;
    if (to || got != 5 || bad || frame_cnt !== 16'd5) begin
      n_fail++; $display("FAIL rot_line: handshakes=%0d frames=%0d cnt=%0d bad=%0d want 5 %0d 5 0", got, line_q.size(), frame_cnt, bad, exp_q.size());
    end
  endtask

  task automatic test_wait_req;
    int n_done;
    bit saw_ready, to;
    do_reset;
    req_data[0 +: DW] = 8'h3C;
    req_valid = 4'b0001;
    tick;
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 8'hC2;
    #1;
    n_done = 0; saw_ready = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (req_ready !== 4'b0000) saw_ready = 1'b1;
      if (tx_done) n_done++;
      if (n_done == FPH) break;
      tick;
    end
    n_tests++;
    if (saw_ready || n_done != FPH) begin
      n_fail++; $display("FAIL wait_ready_held: early_ready=%0d dones=%0d want 0 %0d", saw_ready, n_done, FPH);
    end
    tick;
    n_tests++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL wait_ready_after_done: got %b want 0100", req_ready);
    end
    tick;
    req_valid = '0;
    wait_quiet(200, to);
    n_tests++;
    if (to || frame_cnt !== 16'd2 || grant_id !== 4'd2) begin
      n_fail++; $display("FAIL wait_second: timeout=%0d cnt=%0d gid=%0d want 0 2 2", to, frame_cnt, grant_id);
    end
  endtask

  task automatic test_rst_midframe;
    bit to;
    do_reset;
    req_data[1*DW +: DW] = 8'h99;
    req_valid = 4'b0010;
    tick;
    req_valid = '0;
    tick; tick; tick;
    rst = 1'b1;
    req_valid = 4'b0110;
    #1;
    n_tests++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL rst_ready: got %b want 0000", req_ready);
    end
    tick;
    n_tests++;
    if ({arb_busy, tx_start, tx_data, grant_id, frame_cnt} !== '0) begin
      n_fail++; $display("FAIL rst_midframe: busy=%b start=%b data=%h gid=%0d cnt=%0d want all zero",
                         arb_busy, tx_start, tx_data, grant_id, frame_cnt);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL rst_ptr_cleared: got %b want 0010", req_ready);
    end
    tick;
    req_valid = '0;
    wait_quiet(200, to);
    n_tests++;
    if (to || grant_id !== 4'd1 || frame_cnt !== 16'd1) begin
      n_fail++; $display("FAIL rst_recover: timeout=%0d gid=%0d cnt=%0d want 0 1 1", to, grant_id, frame_cnt);
    end
  endtask

  task automatic test_spurious_done;
    bit to;
    logic [7:0] exp_first;
    do_reset;
    spur_done = 1'b1;
    tick;
    spur_done = 1'b0;
    n_tests++;
    if (frame_cnt !== 16'd0 || arb_busy !== 1'b0) begin
      n_fail++; $display("FAIL spur_idle: cnt=%0d busy=%b want 0 0", frame_cnt, arb_busy);
    end
    f_busy = 1'b1;
    req_data[2*DW +: DW] = 8'h5A;
    req_valid = 4'b0100;
    tick;
    req_valid = '0;
    spur_done = 1'b1;
    tick;
    spur_done = 1'b0;
    tick;
    n_tests++;
    if (tx_start !== 1'b0 || frame_cnt !== 16'd0 || arb_busy !== 1'b1) begin
      n_fail++; $display("FAIL spur_launch: start=%b cnt=%0d busy=%b want 0 0 1", tx_start, frame_cnt, arb_busy);
    end
    f_busy = 1'b0;
    tick;
    exp_first = (FPH == 2) ? tagb(2) : 8'h5A;
    n_tests++;
    if (tx_start !== 1'b1 || tx_data !== exp_first) begin
      n_fail++; $display("FAIL spur_release: start=%b data=%h want 1 %h", tx_start, tx_data, exp_first);
    end
    wait_quiet(200, to);
    n_tests++;
    if (to || frame_cnt !== 16'd1) begin
      n_fail++; $display("FAIL spur_count: timeout=%0d cnt=%0d want 0 1", to, frame_cnt);
    end
  endtask

  task automatic test_req3;
    bit to, bad;
    logic [7:0] exp_q[$];
    do_reset;
    req_data[3*DW +: DW] = 8'h7E;
    req_valid = 4'b1000;
    tick;
    req_valid = '0;
    wait_quiet(300, to);
    if (FPH == 2) exp_q.push_back(8'hA3);
    exp_q.push_back(8'h7E);
    bad = (line_q.size() != exp_q.size());
    for (int k = 0; k < exp_q.size() && !bad; k++) if (line_q[k] !== exp_q[k]) bad = 1'b1;
    n_tests++;
    if (to || bad || frame_cnt !== 16'd1) begin
      n_fail++; $display("FAIL req3_line: timeout=%0d frames=%0d cnt=%0d want 0 %0d 1", to, line_q.size(), frame_cnt, exp_q.size());
    end
  endtask

  task automatic test_random;
    logic [7:0]    exp_q[$];
    logic [NR-1:0] acc, exp_ready;
    logic [7:0]    prev_data;
    bit            prev_start, prev_busy, bad;
    int ptr, left, frames, issued, w, ready_err, pulse_err, stab_err;
    do_reset;
    ptr = 0; left = 0; frames = 0; issued = 0; acc = '0;
    ready_err = 0; pulse_err = 0; stab_err = 0;
    prev_start = 1'b0; prev_busy = 1'b0; prev_data = '0;
    for (int c = 0; c < 20000; c++) begin
      tick;
      req_valid = req_valid & ~acc;
      acc = '0;
      if (issued < 40) begin
        for (int i = 0; i < NR; i++) begin
          if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
            req_data[i*DW +: DW] = 8'($urandom);
            req_valid[i] = 1'b1;
          end
        end
      end
      #1;
      w = mwin(req_valid, ptr);
      exp_ready = (left == 0 && w >= 0) ? 4'(1 << w) : 4'b0000;
      if (req_ready !== exp_ready) ready_err++;
      if (tx_start && prev_start) pulse_err++;
      if (tx_busy && prev_busy && tx_data !== prev_data) stab_err++;
      if (exp_ready != '0) begin
        if (FPH == 2) exp_q.push_back(tagb(w));
        exp_q.push_back(req_data[w*DW +: DW]);
        ptr = (w + 1) % NR;
        left = FPH;
        acc = exp_ready;
        issued++;
      end else if (tx_done && left > 0) begin
        left--;
        if (left == 0) frames++;
      end
      prev_start = tx_start; prev_busy = tx_busy; prev_data = tx_data;
      if (issued >= 40 && left == 0 && (req_valid & ~acc) == '0) break;
    end
    tick;
    req_valid = '0;
    n_tests++;
    if (ready_err != 0 || pulse_err != 0 || stab_err != 0) begin
      n_fail++; $display("FAIL rand_protocol: ready_err=%0d pulse_err=%0d stable_err=%0d want 0 0 0", ready_err, pulse_err, stab_err);
    end
    bad = (line_q.size() != exp_q.size());
    for (int k = 0; k < exp_q.size() && !bad; k++) if (line_q[k] !== exp_q[k]) bad = 1'b1;
    n_tests++;
    if (bad || left != 0 || issued < 40) begin
      n_fail++; $display("FAIL rand_line: frames=%0d want %0d issued=%0d left=%0d", line_q.size(), exp_q.size(), issued, left);
    end
    n_tests++;
    if (frame_cnt !== 16'(frames)) begin
      n_fail++; $display("FAIL rand_frame_cnt: got %0d want %0d", frame_cnt, frames);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_rotation;
    test_wait_req;
    test_rst_midframe;
    test_spurious_done;
    test_req3;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
